carry_resolve_window: RTL and testbench
=======================================

Name: carry_resolve_window

Overview:
- Parametrised carry-resolution and readout engine for the exact (quire) accumulator.
- Scans NUM_BLK banked accumulator blocks LSB-first. Each stored block is a BLK_W fraction plus a signed CARRY_W carry field.
- Ripples the carries block to block and derives the final sign.
- Tracks the most significant 2*BLK_W-bit window containing significant data (nonzero if positive, not-all-ones if negative) for the downstream normaliser/rounder.
- Start/busy/done handshake replaces free-running enable sequencing.

Parameters:
- BLK_W, 64: fraction bits per block.
- CARRY_W, 16: signed carry-field bits per block; must be < BLK_W.
- NUM_BLK, 8: blocks per accumulator; power of two, >= 2.
- BANKS, 2: memory banks, block k in bank k%BANKS; power of two, divides NUM_BLK.
- Derived: IDX_W = clog2(NUM_BLK), ADR_W = max(1, clog2(NUM_BLK/BANKS)), EW = BLK_W+CARRY_W.

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin scan; sampled only when busy=0.
- rd_adr, output, ADR_W: bank entry address = k/BANKS.
- rd_bank, output, BANKS: one-hot bank being read (bit k%BANKS); all-zero when idle. Accumulator uses it as clear-after-read.
- rd_data, input, BANKS*EW: bank b data at [b*EW +: EW]; combinational read, valid same cycle as rd_adr.
- busy, output, 1: scan/pipeline in progress.
- done, output, 1: one-cycle pulse; result outputs valid from this cycle until next start.
- sign, output, 1: quire sign.
- zero, output, 1: quire exactly zero.
- blk_out, output, IDX_W: index of window's upper block.
- frac_out, output, 2*BLK_W: {upper block, lower block or 0}.
- sticky, output, 1: present only with CRW_STICKY_EN.

Behaviour:
- Reset: busy=0, done=0, sign=0, zero=0, blk_out=0, frac_out=0, sticky=0, rd_bank=0, rd_adr=0; state IDLE; carry and trackers cleared. rst mid-scan aborts with no done pulse; the next start runs normally.
- States: IDLE -> SCAN -> DRAIN -> IDLE.
- IDLE -> SCAN: on start&!busy. Clear k=0, carry=0, both trackers. busy=1 from the next cycle.
- start while busy is ignored.
- SCAN, cycle k (0..NUM_BLK-1):
  - Drive rd_adr/rd_bank for block k.
  - sum = bank data + sign-extended carry, modulo 2^EW.
  - carry <= sum[EW-1:BLK_W]; s1_frac <= sum[BLK_W-1:0]; s1_idx <= k; s1_v <= 1.
  - At k=NUM_BLK-1: sign_r <= sum[EW-1], then go to DRAIN.
- Stage 2 (s1_v):
  - pos tracker: if s1_frac != 0, pos_win <= {s1_frac, (s1_idx==pos_idx+1) ? pos_win[hi] : 0}, pos_idx <= s1_idx.
  - neg tracker: same update, with condition s1_frac != all-ones.
- DRAIN: two cycles. done pulses in the second, i.e. NUM_BLK+2 cycles after the start-sampling edge. Same cycle: busy=0 and outputs registered:
  - sign = sign_r.
  - frac_out/blk_out from the neg tracker if sign=1, else the pos tracker.
  - Positive with no nonzero block: zero=1, frac_out=0, blk_out=0.
  - Negative with all blocks all-ones: frac_out=all-ones, blk_out=0, zero=0.
- A start in the done cycle is accepted; it starts a new scan and outputs hold until the next done.
- Carry overflow beyond the top block wraps silently; no saturation.

Optional Feature:
- Macro CRW_STICKY_EN.
- Defined: sticky port exists. On each tracker update, OR in discarded bits:
  - positive: |old_lo, or pos_found when not adjacent;
  - negative: ~&old_lo, or neg_found when not adjacent.
  - sticky = selected tracker's flag, registered at done.
- Undefined: no port, no logic.

Test Plan:
- All banks zero, start -> done exactly 10 cycles after start (defaults); zero=1, sign=0, frac_out=0, blk_out=0; rd_bank sequence 01,10,01,10…, rd_adr 0,0,1,1,2,2,3,3.
- Block3 fraction=64'h1, others 0 -> frac_out={64'h1,64'h0}, blk_out=3, sign=0, zero=0.
- Block0={16'h0001,64'h0}, others 0 -> carry ripples: frac_out={64'h1,64'h0}, blk_out=1, sign=0.
- Block0={16'hFFFF,64'h0}, others 0 -> blocks 1..7 become all-ones, sign=1, blk_out=0, frac_out=0, zero=0.
- Block5=64'hA, block6=64'hB -> frac_out={64'hB,64'hA}, blk_out=6; with CRW_STICKY_EN and block2=1 added -> same window, sticky=1.
- Assert rst in SCAN cycle 4 -> busy=0 next cycle, no done, outputs 0. Start asserted while busy is ignored. A new start then completes in 10 cycles.

Source files
------------

// File: rtl/carry_resolve_window.sv
// Carry-resolution and readout engine for the banked exact (quire) accumulator.
// Optional sticky output for discarded significant bits: define CRW_STICKY_EN.
module carry_resolve_window #(
   parameter int unsigned BLK_W   = 64,
   parameter int unsigned CARRY_W = 16,
   parameter int unsigned NUM_BLK = 8,
   parameter int unsigned BANKS   = 2,
   localparam int unsigned IDX_W  = $clog2(NUM_BLK),
   localparam int unsigned ADR_W  = (NUM_BLK / BANKS > 1) ? $clog2(NUM_BLK / BANKS) : 1,
   localparam int unsigned EW     = BLK_W + CARRY_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADR_W-1:0]      rd_adr,
   output logic [BANKS-1:0]      rd_bank,
   input  logic [BANKS*EW-1:0]   rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sign,
   output logic                  zero,
   output logic [IDX_W-1:0]      blk_out,
   output logic [2*BLK_W-1:0]    frac_out
`ifdef CRW_STICKY_EN
   ,
   output logic                  sticky
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [IDX_W-1:0]   blk_k;
   logic               drn_cnt;
   logic [CARRY_W-1:0] carry;
   logic               sign_r;

   logic               s1_v;
   logic [BLK_W-1:0]   s1_frac;
   logic [IDX_W-1:0]   s1_idx;

   logic [2*BLK_W-1:0] pos_win, neg_win;
   logic [IDX_W-1:0]   pos_idx, neg_idx;
   logic               pos_found, neg_found;
`ifdef CRW_STICKY_EN
   logic               pos_stk, neg_stk;
`endif

   logic               accept_c, last_c, fin_c;
   int unsigned        bsel_c;
   logic [EW-1:0]      blk_data_c, carry_ext_c, sum_c;
   logic               pos_adj_c, neg_adj_c;
   logic [BLK_W-1:0]   pos_lo_c, neg_lo_c;
   logic [IDX_W-1:0]   blk_nxt_c;

   function automatic logic [BANKS-1:0] bank_oh(input logic [IDX_W-1:0] k);
      return BANKS'(1) << (32'(k) % BANKS);
   endfunction

   function automatic logic [ADR_W-1:0] bank_adr(input logic [IDX_W-1:0] k);
      return ADR_W'(32'(k) / BANKS);
   endfunction

   // Sequencing: IDLE -> SCAN (one block per cycle) -> DRAIN (two cycles) -> IDLE
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      fin_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !busy) begin
               accept_c  = 1'b1;
               state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (blk_k == IDX_W'(NUM_BLK - 1)) begin
               last_c    = 1'b1;
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drn_cnt) begin
               fin_c     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Block read and carry add; the add wraps modulo 2^EW
   always_comb begin
      bsel_c      = 32'(blk_k) % BANKS;
      blk_data_c  = rd_data[bsel_c*EW +: EW];
      carry_ext_c = {{BLK_W{carry[CARRY_W-1]}}, carry};
      sum_c       = blk_data_c + carry_ext_c;
      blk_nxt_c   = blk_k + IDX_W'(1);
   end

   // Window trackers keep the previous upper block only if it sits directly below
   always_comb begin
      pos_adj_c = (s1_idx == IDX_W'(pos_idx + IDX_W'(1)));
      neg_adj_c = (s1_idx == IDX_W'(neg_idx + IDX_W'(1)));
      pos_lo_c  = pos_adj_c ? pos_win[2*BLK_W-1:BLK_W] : {BLK_W{1'b0}};
      neg_lo_c  = neg_adj_c ? neg_win[2*BLK_W-1:BLK_W] : {BLK_W{1'b0}};
   end

   // Scan counter, read port, carry chain and stage-1 register
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_k   <= '0;
         drn_cnt <= 1'b0;
         carry   <= '0;
         sign_r  <= 1'b0;
         rd_adr  <= '0;
         rd_bank <= '0;
         s1_v    <= 1'b0;
         s1_frac <= '0;
         s1_idx  <= '0;
      end else begin
         drn_cnt <= (state == S_DRAIN) && !drn_cnt;
         s1_v    <= (state == S_SCAN);
         if (accept_c) begin
            blk_k   <= '0;
            carry   <= '0;
            rd_adr  <= bank_adr(IDX_W'(0));
            rd_bank <= bank_oh(IDX_W'(0));
         end else if (state == S_SCAN) begin
            blk_k   <= blk_nxt_c;
            carry   <= sum_c[EW-1:BLK_W];
            s1_frac <= sum_c[BLK_W-1:0];
            s1_idx  <= blk_k;
            if (last_c) begin
               sign_r  <= sum_c[EW-1];
               rd_adr  <= '0;
               rd_bank <= '0;
            end else begin
               rd_adr  <= bank_adr(blk_nxt_c);
               rd_bank <= bank_oh(blk_nxt_c);
            end
         end
      end
   end

   // Stage 2: most significant window for each sign hypothesis
   always_ff @(posedge clk) begin
      if (rst || accept_c) begin
         pos_win   <= '0;
         pos_idx   <= '0;
         pos_found <= 1'b0;
         neg_win   <= '0;
         neg_idx   <= '0;
         neg_found <= 1'b0;
`ifdef CRW_STICKY_EN
         pos_stk   <= 1'b0;
         neg_stk   <= 1'b0;
`endif
      end else if (s1_v) begin
         if (s1_frac != {BLK_W{1'b0}}) begin
            pos_win   <= {s1_frac, pos_lo_c};
            pos_idx   <= s1_idx;
            pos_found <= 1'b1;
`ifdef CRW_STICKY_EN
            pos_stk   <= pos_stk | (pos_found & (pos_adj_c ? (|pos_win[BLK_W-1:0]) : 1'b1));
`endif
         end
         if (s1_frac != {BLK_W{1'b1}}) begin
            neg_win   <= {s1_frac, neg_lo_c};
            neg_idx   <= s1_idx;
            neg_found <= 1'b1;
`ifdef CRW_STICKY_EN
            neg_stk   <= neg_stk | (neg_found & (neg_adj_c ? ~(&neg_win[BLK_W-1:0]) : 1'b1));
`endif
         end
      end
   end

   // Handshake and result registers; results hold until the next completion
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         sign     <= 1'b0;
         zero     <= 1'b0;
         blk_out  <= '0;
         frac_out <= '0;
`ifdef CRW_STICKY_EN
         sticky   <= 1'b0;
`endif
      end else begin
         done <= fin_c;
         if (accept_c)   busy <= 1'b1;
         else if (fin_c) busy <= 1'b0;
         if (fin_c) begin
            sign <= sign_r;
            if (sign_r) begin
               zero     <= 1'b0;
               blk_out  <= neg_found ? neg_idx : '0;
               frac_out <= neg_found ? neg_win : {(2*BLK_W){1'b1}};
`ifdef CRW_STICKY_EN
               sticky   <= neg_stk;
`endif
            end else begin
               zero     <= !pos_found;
               blk_out  <= pos_found ? pos_idx : '0;
               frac_out <= pos_found ? pos_win : '0;
`ifdef CRW_STICKY_EN
               sticky   <= pos_stk;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_carry_resolve_window.sv
// Directed bench for carry_resolve_window with default parameters.
module tb_carry_resolve_window;

   localparam int unsigned BLK_W   = 64;
   localparam int unsigned CARRY_W = 16;
   localparam int unsigned NUM_BLK = 8;
   localparam int unsigned BANKS   = 2;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned ADR_W   = 2;
   localparam int unsigned EW      = BLK_W + CARRY_W;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [ADR_W-1:0]    rd_adr;
   logic [BANKS-1:0]    rd_bank;
   logic [BANKS*EW-1:0] rd_data;
   logic                busy, done, sign, zero;
   logic [IDX_W-1:0]    blk_out;
   logic [2*BLK_W-1:0]  frac_out;
`ifdef CRW_STICKY_EN
   logic                sticky;
`endif

   logic [EW-1:0] mem [NUM_BLK];
   int n_chk = 0;
   int n_fail = 0;
   int cyc;
   int dcount;
   logic [BLK_W-1:0] ones;

   always #5 clk = ~clk;

   carry_resolve_window #(
      .BLK_W(BLK_W), .CARRY_W(CARRY_W), .NUM_BLK(NUM_BLK), .BANKS(BANKS)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_adr(rd_adr), .rd_bank(rd_bank), .rd_data(rd_data),
      .busy(busy), .done(done), .sign(sign), .zero(zero),
      .blk_out(blk_out), .frac_out(frac_out)
`ifdef CRW_STICKY_EN
      , .sticky(sticky)
`endif
   );

   always_comb begin
      for (int b = 0; b < int'(BANKS); b++)
         rd_data[b*EW +: EW] = mem[int'(rd_adr)*int'(BANKS) + b];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < int'(NUM_BLK); i++) mem[i] = '0;
   endtask

   task automatic check_res(input string tag, input logic s, input logic z,
                            input logic [IDX_W-1:0] blk, input logic [127:0] frac,
                            input logic stk);
      chk({tag, "_sign"}, 128'(sign), 128'(s));
      chk({tag, "_zero"}, 128'(zero), 128'(z));
      chk({tag, "_blk"},  128'(blk_out), 128'(blk));
      chk({tag, "_frac"}, frac_out, frac);
`ifdef CRW_STICKY_EN
      chk({tag, "_sticky"}, 128'(sticky), 128'(stk));
`else
      if (stk === 1'bx) $display("unreachable");
`endif
   endtask

   // Starts a scan and returns in the done cycle; cyc counts edges after the start edge
   task automatic do_scan(input bit seq, input bit poke, input bit hold,
                          input logic [127:0] hold_val, output int cyc_o);
      int c;
      bit got;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      got = 1'b0;
      chk("busy_after_start", 128'(busy), 128'(1));
      while (!got && c < 40) begin
         if (seq && c < 8) begin
            chk($sformatf("rd_bank_%0d", c), 128'(rd_bank), (c % 2 == 0) ? 128'h1 : 128'h2);
            chk($sformatf("rd_adr_%0d", c), 128'(rd_adr), 128'(c / 2));
         end
         if (seq && c == 8) chk("rd_bank_idle", 128'(rd_bank), 128'h0);
         if (poke && c == 3) start = 1'b1;
         if (poke && c == 4) start = 1'b0;
         if (hold && c == 5) chk("hold_frac", frac_out, hold_val);
         if (done) got = 1'b1;
         else begin
            @(posedge clk); #1;
            c++;
         end
      end
      if (!got) chk("done_timeout", 128'(0), 128'(1));
      else      chk("busy_at_done", 128'(busy), 128'(0));
      cyc_o = c;
   endtask

   initial begin
      ones  = {BLK_W{1'b1}};
      rst   = 1'b1;
      start = 1'b0;
      clear_mem();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_rd_bank", 128'(rd_bank), 128'(0));
      chk("rst_rd_adr", 128'(rd_adr), 128'(0));
      check_res("rst", 1'b0, 1'b0, 3'd0, 128'h0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      // all blocks zero, with read-port sequence
      do_scan(1'b1, 1'b0, 1'b0, 128'h0, cyc);
      chk("t1_latency", 128'(cyc), 128'(10));
      check_res("t1", 1'b0, 1'b1, 3'd0, 128'h0, 1'b0);
      @(posedge clk); #1;
      chk("t1_done_pulse", 128'(done), 128'(0));

      // single bit in block 3
      clear_mem();
      mem[3] = {16'h0000, 64'h1};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t2", 1'b0, 1'b0, 3'd3, {64'h1, 64'h0}, 1'b0);
      @(posedge clk); #1;

      // carry ripples from block 0 into block 1
      clear_mem();
      mem[0] = {16'h0001, 64'h0};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t3", 1'b0, 1'b0, 3'd1, {64'h1, 64'h0}, 1'b0);
      @(posedge clk); #1;

      // negative carry turns blocks 1..7 all-ones
      clear_mem();
      mem[0] = {16'hFFFF, 64'h0};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t4", 1'b1, 1'b0, 3'd0, 128'h0, 1'b0);
      @(posedge clk); #1;

      // adjacent pair
      clear_mem();
      mem[5] = {16'h0000, 64'hA};
      mem[6] = {16'h0000, 64'hB};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t5", 1'b0, 1'b0, 3'd6, {64'hB, 64'hA}, 1'b0);
      @(posedge clk); #1;

      // lower significant block discarded below the window
      mem[2] = {16'h0000, 64'h1};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t5b", 1'b0, 1'b0, 3'd6, {64'hB, 64'hA}, 1'b1);
      @(posedge clk); #1;

      // negative, every block all-ones
      for (int i = 0; i < 7; i++) mem[i] = {16'h0000, ones};
      mem[7] = {16'hFFFF, ones};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t6", 1'b1, 1'b0, 3'd0, {128{1'b1}}, 1'b0);
      @(posedge clk); #1;

      // negative with one non-all-ones block
      mem[4] = {16'h0000, 64'hFFFF_FFFF_FFFF_FFFE};
      do_scan(1'b0, 1'b0, 1'b0, 128'h0, cyc);
      check_res("t7", 1'b1, 1'b0, 3'd4, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0}, 1'b0);
      @(posedge clk); #1;

      // reset in scan cycle 4 aborts with cleared outputs and no done
      clear_mem();
      mem[5] = {16'h0000, 64'hA};
      mem[6] = {16'h0000, 64'hB};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_rd_bank", 128'(rd_bank), 128'(0));
      check_res("abort", 1'b0, 1'b0, 3'd0, 128'h0, 1'b0);
      dcount = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      chk("abort_no_done", 128'(dcount), 128'(0));

      // start while busy is ignored
      do_scan(1'b0, 1'b1, 1'b0, 128'h0, cyc);
      chk("poke_latency", 128'(cyc), 128'(10));
      check_res("poke", 1'b0, 1'b0, 3'd6, {64'hB, 64'hA}, 1'b0);

      // start in the done cycle; previous result holds; carry out of top block wraps
      clear_mem();
      mem[7] = {16'h8000, 64'h0};
      do_scan(1'b0, 1'b0, 1'b1, {64'hB, 64'hA}, cyc);
      chk("chain_latency", 128'(cyc), 128'(10));
      check_res("t8", 1'b1, 1'b0, 3'd7, 128'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
